// File: rtl/filter_resp_meter.sv
// filter_resp_meter: settle-then-window peak/sum |x| monitor with valid/ready result.
// Optional sum accumulator built only when FILTER_RESP_MEAN_EN is defined.
module filter_resp_meter #(
   parameter int DATA_W     = 11,
   parameter int SETTLE_LEN = 25,
   parameter int WIN_LEN    = 250
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    sample_en,
   input  logic signed [DATA_W-1:0]                in,
   input  logic                                    start,
   output logic                                    busy,
   output logic        [DATA_W-1:0]                peak,
   output logic        [DATA_W+$clog2(WIN_LEN+1)-1:0] sum_abs,
   output logic                                    result_valid,
   input  logic                                    result_ready
);

   localparam int MAX_LEN = (SETTLE_LEN > WIN_LEN) ? SETTLE_LEN : WIN_LEN;
   localparam int CW      = $clog2(MAX_LEN + 1);
   localparam int SL_M1   = (SETTLE_LEN > 0) ? SETTLE_LEN - 1 : 0;
   localparam int WL_M1   = WIN_LEN - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_MEASURE,
      S_REPORT
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] peak_acc_q, peak_acc_d;
   logic [DATA_W-1:0] peak_q, peak_d;
   logic              valid_q, valid_d;

   logic [DATA_W:0]   in_ext;
   logic [DATA_W:0]   in_neg;
   logic [DATA_W-1:0] mag;
   logic [DATA_W-1:0] peak_new;
   logic              settle_last;
   logic              acc_clr;
   logic              acc_en;
   logic              win_last;

   // Magnitude in one extra bit so the most negative sample maps exactly.
   assign in_ext = {in[DATA_W-1], in};
   assign in_neg = -in_ext;
   assign mag    = in[DATA_W-1] ? in_neg[DATA_W-1:0] : in_ext[DATA_W-1:0];

   assign peak_new = (mag > peak_acc_q) ? mag : peak_acc_q;

   // Zero settle length leaves SETTLE on the first cycle regardless of strobes.
   assign settle_last = (SETTLE_LEN == 0) ? 1'b1 :
                        (sample_en && (cnt_q == CW'(SL_M1)));

   assign acc_clr  = (state_q == S_IDLE) && start;
   assign acc_en   = (state_q == S_MEASURE) && sample_en;
   assign win_last = acc_en && (cnt_q == CW'(WL_M1));

   // Next-state, counter and peak tracking.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      peak_acc_d = peak_acc_q;
      peak_d     = peak_q;
      valid_d    = valid_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_SETTLE;
               cnt_d      = '0;
               peak_acc_d = '0;
            end
         end
         S_SETTLE: begin
            if (settle_last) begin
               state_d = S_MEASURE;
               cnt_d   = '0;
            end else if (sample_en) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_MEASURE: begin
            if (acc_en) begin
               peak_acc_d = peak_new;
               cnt_d      = cnt_q + CW'(1);
            end
            if (win_last) begin
               state_d = S_REPORT;
               cnt_d   = '0;
               peak_d  = peak_new;
               valid_d = 1'b1;
            end
         end
         S_REPORT: begin
            if (result_ready) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // Control and peak registers; reset aborts any measurement.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         peak_acc_q <= '0;
         peak_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         peak_acc_q <= peak_acc_d;
         peak_q     <= peak_d;
         valid_q    <= valid_d;
      end
   end

   assign busy         = (state_q == S_SETTLE) || (state_q == S_MEASURE);
   assign peak         = peak_q;
   assign result_valid = valid_q;

`ifdef FILTER_RESP_MEAN_EN
   localparam int SUM_W = DATA_W + $clog2(WIN_LEN + 1);

   logic [SUM_W-1:0] sum_acc_q, sum_acc_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [SUM_W-1:0] sum_new;

   assign sum_new = sum_acc_q + SUM_W'(mag);

   // Running sum, published together with the peak on entry to REPORT.
   always_comb begin
      sum_acc_d = sum_acc_q;
      sum_d     = sum_q;
      if (acc_clr) begin
         sum_acc_d = '0;
      end else if (acc_en) begin
         sum_acc_d = sum_new;
      end
      if (win_last) begin
         sum_d = sum_new;
      end
   end

   // Sum registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum_acc_q <= '0;
         sum_q     <= '0;
      end else begin
         sum_acc_q <= sum_acc_d;
         sum_q     <= sum_d;
      end
   end

   assign sum_abs = sum_q;
`else
   assign sum_abs = '0;
`endif

endmodule

// File: tb/tb_filter_resp_meter.sv
// tb_filter_resp_meter: randomized windows checked against a queue-based model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_filter_resp_meter;

   localparam int DW    = 11;
   localparam int SL    = 25;
   localparam int WL    = 250;
   localparam int SUM_W = DW + $clog2(WL + 1);

   logic                 clk;
   logic                 reset;
   logic                 sample_en;
   logic signed [DW-1:0] in_s;
   logic                 start;
   logic                 busy;
   logic [DW-1:0]        peak;
   logic [SUM_W-1:0]     sum_abs;
   logic                 result_valid;
   logic                 result_ready;

   int tests_run;
   int tests_failed;
   int samples[$];

   filter_resp_meter #(
      .DATA_W    (DW),
      .SETTLE_LEN(SL),
      .WIN_LEN   (WL)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sample_en   (sample_en),
      .in          (in_s),
      .start       (start),
      .busy        (busy),
      .peak        (peak),
      .sum_abs     (sum_abs),
      .result_valid(result_valid),
      .result_ready(result_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int abs_i(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int exp_peak();
      int m;
      m = 0;
      for (int i = SL; i < SL + WL; i++)
         if (abs_i(samples[i]) > m) m = abs_i(samples[i]);
      return m;
   endfunction

   function automatic int exp_sum();
      int s;
      s = 0;
`ifdef FILTER_RESP_MEAN_EN
      for (int i = SL; i < SL + WL; i++) s += abs_i(samples[i]);
`endif
      return s;
   endfunction

   function automatic int gen(input int mode, input int k);
      real ph;
      int  v;
      case (mode)
         0: v = -1024;
         1: v = (k < SL) ? 1000 : ((k % 2 == 0) ? 300 : -300);
         2: v = $urandom_range(2047) - 1024;
         3: begin
            ph = 2.0 * 3.14159265358979 * 0.21 * k;
            v  = $rtoi($floor(1023.0 * $sin(ph) + 0.5));
         end
         default: v = ($urandom_range(7) == 0) ? -1024 :
                      ($urandom_range(200) - 100);
      endcase
      return v;
   endfunction

   task automatic strobe(input int v);
      in_s      = DW'(v);
      sample_en = 1'b1;
      samples.push_back(v);
      @(negedge clk);
      sample_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic do_start();
      samples.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_result(input string name);
      logic [DW-1:0]    ep;
      logic [SUM_W-1:0] es;
      ep = DW'(exp_peak());
      es = SUM_W'(exp_sum());
      tests_run++;
      if (result_valid !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s valid/busy: got %b/%b want 1/0",
                  name, result_valid, busy);
      end
      tests_run++;
      if (peak !== ep) begin
         tests_failed++;
         $display("FAIL %s peak: got %0d want %0d", name, peak, ep);
      end
      tests_run++;
      if (sum_abs !== es) begin
         tests_failed++;
         $display("FAIL %s sum_abs: got %0d want %0d", name, sum_abs, es);
      end
   endtask

   task automatic run_window(input int mode, input string name);
      do_start();
      for (int k = 0; k < SL + WL; k++) begin
         if (k == SL + WL - 1) begin
            tests_run++;
            if (result_valid !== 1'b0 || busy !== 1'b1) begin
               tests_failed++;
               $display("FAIL %s early: valid=%b busy=%b want 0/1",
                        name, result_valid, busy);
            end
         end
         strobe(gen(mode, k));
      end
      check_result(name);
   endtask

   task automatic accept(input string name);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      tests_run++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s accept: valid=%b busy=%b want 0/0",
                  name, result_valid, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      tests_run++;
      if (busy !== 1'b0 || result_valid !== 1'b0 ||
          peak !== '0 || sum_abs !== '0) begin
         tests_failed++;
         $display("FAIL reset: busy=%b valid=%b peak=%0d sum=%0d want 0",
                  busy, result_valid, peak, sum_abs);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_neg_full();
      run_window(0, "neg_full");
      accept("neg_full");
   endtask

   task automatic test_settle_excluded();
      run_window(1, "settle_excl");
      accept("settle_excl");
   endtask

   task automatic test_abort_reset();
      do_start();
      for (int k = 0; k < SL + 100; k++) strobe(gen(2, k));
      reset = 1'b0;
      #1;
      tests_run++;
      if (busy !== 1'b0 || result_valid !== 1'b0 || peak !== '0) begin
         tests_failed++;
         $display("FAIL abort: busy=%b valid=%b peak=%0d want 0/0/0",
                  busy, result_valid, peak);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_window(2, "after_abort");
      accept("after_abort");
   endtask

   task automatic test_hold_ready();
      int bad;
      logic [DW-1:0] ep;
      run_window(4, "hold");
      ep  = DW'(exp_peak());
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         in_s      = DW'($urandom_range(2047));
         start     = c[0];
         sample_en = ~c[0];
         @(negedge clk);
         tests_run++;
         if (result_valid !== 1'b1 || peak !== ep || busy !== 1'b0) begin
            tests_failed++;
            bad++;
            if (bad < 4)
               $display("FAIL hold c=%0d: valid=%b peak=%0d want 1/%0d",
                        c, result_valid, peak, ep);
         end
      end
      start     = 1'b0;
      sample_en = 1'b0;
      accept("hold");
   endtask

   task automatic test_start_report();
      run_window(2, "start_rpt");
      start        = 1'b1;
      result_ready = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      result_ready = 1'b0;
      tests_run++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_rpt exit: valid=%b busy=%b want 0/0",
                  result_valid, busy);
      end
      repeat (5) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_rpt idle: busy=%b want 0", busy);
      end
      run_window(3, "start_rpt2");
      accept("start_rpt2");
   endtask

   task automatic test_random();
      for (int w = 0; w < 3; w++) begin
         run_window(2 + 2 * (w % 2), "random");
         accept("random");
      end
   endtask

   task automatic test_sine();
      run_window(3, "sine");
      accept("sine");
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      sample_en    = 1'b0;
      start        = 1'b0;
      result_ready = 1'b0;
      in_s         = '0;
      reset        = 1'b0;
      @(negedge clk);
      test_reset();
      test_neg_full();
      test_settle_excluded();
      test_abort_reset();
      test_hold_ready();
      test_start_report();
      test_random();
      test_sine();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
